// File: rtl/rv32imf_ff_pkg.sv
// Shared types for the set-bit iterator: scan direction and controller state.
package rv32imf_ff_pkg;

  typedef enum logic {
    FF_LSB_FIRST = 1'b0,
    FF_MSB_FIRST = 1'b1
  } ff_dir_e;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } ff_state_e;

endpackage

// File: rtl/rv32imf_ff_one_iter_if.sv
// Vector-in / index-beat-out handshake bundle for rv32imf_ff_one_iter.
interface rv32imf_ff_one_iter_if #(
  parameter int LEN = 32
);
  localparam int IDX_W = $clog2(LEN);
  localparam int SEQ_W = $clog2(LEN + 1);

  logic             in_valid_i;
  logic             in_ready_o;
  logic [LEN-1:0]   in_vec_i;
  logic             in_msb_first_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [IDX_W-1:0] out_idx_o;
  logic [SEQ_W-1:0] out_seq_o;
  logic             out_last_o;
  logic             out_empty_o;

  // The iterator block itself.
  modport slave (
    input  in_valid_i, in_vec_i, in_msb_first_i, out_ready_i,
    output in_ready_o, out_valid_o, out_idx_o, out_seq_o, out_last_o, out_empty_o
  );

  // Producer of vectors and consumer of beats.
  modport master (
    output in_valid_i, in_vec_i, in_msb_first_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_idx_o, out_seq_o, out_last_o, out_empty_o
  );
endinterface

// File: rtl/rv32imf_ff_dir.sv
// Direction-aware find-first-set: log-depth lowest-set-bit tree, MSB-first via
// bit reversal of the input and complement of the found index.
module rv32imf_ff_dir
  import rv32imf_ff_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic [LEN-1:0]         vec,
  input  ff_dir_e                dir,
  output logic [$clog2(LEN)-1:0] idx,
  output logic                   none,
  output logic                   single
);
  localparam int IDX_W = $clog2(LEN);
  localparam int P     = 1 << IDX_W;

  logic [P-1:0]     scan;
  logic [IDX_W-1:0] low;
  logic             any;

  // Bits above LEN (non power-of-two widths) are padded with zero.
  always_comb begin
    scan = '0;
    for (int j = 0; j < LEN; j++) begin
      scan[j] = (dir == FF_MSB_FIRST) ? vec[LEN-1-j] : vec[j];
    end
  end

  for (genvar lv = 0; lv <= IDX_W; lv++) begin : g_lvl
    localparam int N = P >> lv;
    logic [N-1:0]            v;
    logic [N-1:0][IDX_W-1:0] ix;
    if (lv == 0) begin : g_leaf
      assign v  = scan;
      assign ix = '0;
    end else begin : g_node
      for (genvar nd = 0; nd < N; nd++) begin : g_nd
        // The lower half wins; otherwise take the upper half and set this level's bit.
        assign v[nd]  = g_lvl[lv-1].v[2*nd] | g_lvl[lv-1].v[2*nd+1];
        assign ix[nd] = g_lvl[lv-1].v[2*nd] ? g_lvl[lv-1].ix[2*nd]
                                            : (g_lvl[lv-1].ix[2*nd+1] | IDX_W'(1 << (lv-1)));
      end
    end
  end

  assign low    = g_lvl[IDX_W].ix[0];
  assign any    = g_lvl[IDX_W].v[0];
  assign none   = ~any;
  assign single = any & ((vec & (vec - LEN'(1))) == '0);
  assign idx    = none                  ? '0
                : (dir == FF_MSB_FIRST) ? (IDX_W'(LEN - 1) - low)
                :                         low;

endmodule

// File: rtl/rv32imf_ff_one_iter.sv
// Sequential set-bit iterator: accepts a vector, then emits one beat per set
// bit (index, ordinal, last, empty) in the requested order.
module rv32imf_ff_one_iter
  import rv32imf_ff_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  abort_i,
  rv32imf_ff_one_iter_if.slave  io
);
  localparam int IDX_W = $clog2(LEN);
  localparam int SEQ_W = $clog2(LEN + 1);

  ff_state_e        state;
  logic [LEN-1:0]   resid;
  ff_dir_e          dir;
  logic [SEQ_W-1:0] seq;

  logic [IDX_W-1:0] cur_idx;
  logic             cur_none;
  logic             cur_single;
  logic             in_iter;
  logic             cur_last;
  logic             in_ready;
  logic             accept;
  logic             fire;

  rv32imf_ff_dir #(
    .LEN (LEN)
  ) u_dir (
    .vec    (resid),
    .dir    (dir),
    .idx    (cur_idx),
    .none   (cur_none),
    .single (cur_single)
  );

  assign in_iter  = (state == ITER);
  assign cur_last = cur_none | cur_single;

  // Zero-bubble reload: a new vector may enter on the cycle the last beat leaves.
  assign in_ready = ~abort_i & (~in_iter | (io.out_ready_i & cur_last));
  assign accept   = io.in_valid_i & in_ready;
  assign fire     = in_iter & io.out_ready_i;

  assign io.in_ready_o  = in_ready;
  assign io.out_valid_o = in_iter;
  assign io.out_idx_o   = in_iter ? cur_idx : '0;
  assign io.out_seq_o   = in_iter ? seq : '0;
  assign io.out_last_o  = in_iter & cur_last;
  assign io.out_empty_o = in_iter & cur_none;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      resid <= '0;
      dir   <= FF_LSB_FIRST;
      seq   <= '0;
    end else if (abort_i) begin
      // The beat presented this cycle is treated as not consumed.
      state <= IDLE;
      resid <= '0;
      seq   <= '0;
    end else if (accept) begin
      state <= ITER;
      resid <= io.in_vec_i;
      dir   <= ff_dir_e'(io.in_msb_first_i);
      seq   <= '0;
    end else if (fire) begin
      resid <= resid & ~(LEN'(1) << cur_idx);
      seq   <= seq + SEQ_W'(1);
      if (cur_last) state <= IDLE;
    end
  end

endmodule

// File: tb/tb_rv32imf_ff_one_iter.sv
// Directed-vector bench for rv32imf_ff_one_iter at LEN=8 with hand-computed beats.
module tb_rv32imf_ff_one_iter;
  localparam int LEN = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic abort;
  int   n_chk = 0;
  int   n_err = 0;

  rv32imf_ff_one_iter_if #(.LEN(LEN)) io ();

  rv32imf_ff_one_iter #(.LEN(LEN)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .abort_i (abort),
    .io      (io.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, io.out_valid_o, 0);
    chk({tag, "_ready"}, io.in_ready_o, 1);
    chk({tag, "_idx"},   io.out_idx_o, 0);
    chk({tag, "_seq"},   io.out_seq_o, 0);
    chk({tag, "_last"},  io.out_last_o, 0);
    chk({tag, "_empty"}, io.out_empty_o, 0);
  endtask

  task automatic chk_beat(input string tag, input int idx, input int seq,
                          input bit last, input bit empty);
    chk({tag, "_valid"}, io.out_valid_o, 1);
    chk({tag, "_idx"},   io.out_idx_o, idx);
    chk({tag, "_seq"},   io.out_seq_o, seq);
    chk({tag, "_last"},  io.out_last_o, last);
    chk({tag, "_empty"}, io.out_empty_o, empty);
  endtask

  // Present a vector and hold it until accepted; afterwards we sit in cycle N+1.
  task automatic send(input string tag, input logic [7:0] vec, input bit msb);
    int w = 0;
    io.in_valid_i     = 1'b1;
    io.in_vec_i       = vec;
    io.in_msb_first_i = msb;
    #1;
    while (!io.in_ready_o && w < 20) begin
      tick();
      w++;
    end
    chk({tag, "_accept_ready"}, io.in_ready_o, 1);
    tick();
    io.in_valid_i = 1'b0;
    io.in_vec_i   = '0;
  endtask

  // Expected indices packed one per nibble, first beat in the low nibble.
  task automatic run_beats(input string tag, input int n, input logic [31:0] idxs,
                           input bit empty);
    for (int k = 0; k < n; k++) begin
      chk_beat($sformatf("%s_b%0d", tag, k), int'(idxs[4*k +: 4]), k, k == n - 1, empty);
      tick();
    end
    chk({tag, "_done_valid"}, io.out_valid_o, 0);
    chk({tag, "_done_ready"}, io.in_ready_o, 1);
  endtask

  initial begin
    rst_n             = 1'b0;
    abort             = 1'b0;
    io.in_valid_i     = 1'b0;
    io.in_vec_i       = '0;
    io.in_msb_first_i = 1'b0;
    io.out_ready_i    = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk_idle("reset");

    send("lsb_a4", 8'hA4, 1'b0);
    run_beats("lsb_a4", 3, 32'h752, 1'b0);

    send("msb_a4", 8'hA4, 1'b1);
    run_beats("msb_a4", 3, 32'h257, 1'b0);

    send("zero", 8'h00, 1'b0);
    run_beats("zero", 1, 32'h0, 1'b1);

    send("zero_msb", 8'h00, 1'b1);
    run_beats("zero_msb", 1, 32'h0, 1'b1);

    send("full", 8'hFF, 1'b0);
    run_beats("full", 8, 32'h76543210, 1'b0);

    // Backpressure: beat must hold steady while the consumer stalls.
    io.out_ready_i = 1'b0;
    send("bp", 8'h11, 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk_beat($sformatf("bp_hold%0d", c), 0, 0, 1'b0, 1'b0);
      chk("bp_hold_ready", io.in_ready_o, 0);
      tick();
    end
    io.out_ready_i = 1'b1;
    #1;
    run_beats("bp", 2, 32'h40, 1'b0);

    // Back-to-back: next vector rides in on the last beat of the previous one.
    send("b2b", 8'h01, 1'b0);
    io.in_valid_i     = 1'b1;
    io.in_vec_i       = 8'h80;
    io.in_msb_first_i = 1'b1;
    #1;
    chk_beat("b2b_first", 0, 0, 1'b1, 1'b0);
    chk("b2b_ready", io.in_ready_o, 1);
    tick();
    io.in_valid_i = 1'b0;
    #1;
    chk_beat("b2b_second", 7, 0, 1'b1, 1'b0);
    tick();
    chk("b2b_done_valid", io.out_valid_o, 0);

    // Abort on the second beat of 8'h0F.
    io.in_msb_first_i = 1'b0;
    send("abort", 8'h0F, 1'b0);
    chk_beat("abort_b0", 0, 0, 1'b0, 1'b0);
    tick();
    abort = 1'b1;
    #1;
    chk_beat("abort_b1", 1, 1, 1'b0, 1'b0);
    chk("abort_ready_low", io.in_ready_o, 0);
    tick();
    abort = 1'b0;
    #1;
    chk_idle("abort_after");
    tick();
    chk_idle("abort_quiet");

    // Reset in the middle of a vector.
    send("rst", 8'h0F, 1'b0);
    chk_beat("rst_b0", 0, 0, 1'b0, 1'b0);
    tick();
    io.out_ready_i = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk_idle("rst_after");
    io.out_ready_i = 1'b1;
    tick();
    chk_idle("rst_quiet");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
